noise_reg_file: RTL and testbench

CPU-facing register file and frame sequencer for the APU noise channel. Decodes byte writes and reads to NR41–NR44 (FF20–FF23), holds the register fields, and drives them onto the noise channel's configuration inputs. Emits a one-cycle `trigger` pulse on NR44 writes, and generates the `lenClk` and `envClk` timing pulses. Sits between the APU bus decoder and `noiseChannel`.

---
 rtl/noise_reg_file.sv | 129 ++++++++++++
 tb/tb_noise_reg_file.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/noise_reg_file.sv
// NR41-NR44 register file and 512 Hz frame sequencer for the APU noise channel.
// Optional read-back path is built only when NOISE_REG_READBACK_EN is defined.
module noise_reg_file #(
    parameter int FS_DIV = 8192
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       apuEnable,
    input  logic [1:0] addr,
    input  logic       wrEn,
    input  logic [7:0] wrData,
    input  logic       rdEn,
    output logic [7:0] rdData,
    output logic       rdValid,
    output logic [5:0] lenLoad,
    output logic [3:0] startVol,
    output logic       envAdd,
    output logic [2:0] envPeriod,
    output logic [3:0] clkShift,
    output logic       widthMode,
    output logic [2:0] divisor,
    output logic       lenEnable,
    output logic       trigger,
    output logic       dacEnable,
    output logic       lenClk,
    output logic       envClk
);

    localparam int PW = (FS_DIV > 1) ? $clog2(FS_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(FS_DIV - 1);

    logic [7:0]    nr42;
    logic [7:0]    nr43;
    logic [PW-1:0] presc;
    logic [2:0]    step;
    logic [2:0]    step_next;
    logic          active;

    assign active    = resetN && apuEnable;
    assign startVol  = nr42[7:4];
    assign envAdd    = nr42[3];
    assign envPeriod = nr42[2:0];
    assign clkShift  = nr43[7:4];
    assign widthMode = nr43[3];
    assign divisor   = nr43[2:0];
    assign dacEnable = |nr42[7:3];
    assign step_next = step + 3'd1;

    // Register fields: powering the APU down wipes every field.
    always_ff @(posedge clk) begin
        if (!active) begin
            lenLoad   <= '0;
            nr42      <= '0;
            nr43      <= '0;
            lenEnable <= 1'b0;
        end else if (wrEn) begin
            case (addr)
                2'd0: lenLoad   <= wrData[5:0];
                2'd1: nr42      <= wrData;
                2'd2: nr43      <= wrData;
                2'd3: lenEnable <= wrData[6];
                default: ;
            endcase
        end
    end

    // Trigger needs the DAC on; NR42 cannot change in the same access as NR44.
    always_ff @(posedge clk) begin
        if (!active) begin
            trigger <= 1'b0;
        end else begin
            trigger <= wrEn && (addr == 2'd3) && wrData[7] && dacEnable;
        end
    end

    // Frame sequencer: pulses are registered alongside the step they announce.
    always_ff @(posedge clk) begin
        if (!active) begin
            presc  <= '0;
            step   <= '0;
            lenClk <= 1'b0;
            envClk <= 1'b0;
        end else if (presc == PRESC_LAST) begin
            presc  <= '0;
            step   <= step_next;
            lenClk <= ~step_next[0];
            envClk <= (step_next == 3'd7);
        end else begin
            presc  <= presc + PW'(1);
            lenClk <= 1'b0;
            envClk <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            rdValid <= 1'b0;
        end else begin
            rdValid <= rdEn;
        end
    end

`ifdef NOISE_REG_READBACK_EN
    logic [7:0] rd_mux;

    // While powered down the fields read as zero even before the clear lands.
    always_comb begin
        rd_mux = 8'hFF;
        case (addr)
            2'd0: rd_mux = 8'hFF;
            2'd1: rd_mux = apuEnable ? nr42 : 8'h00;
            2'd2: rd_mux = apuEnable ? nr43 : 8'h00;
            2'd3: rd_mux = {1'b1, apuEnable & lenEnable, 6'h3F};
            default: rd_mux = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            rdData <= 8'h00;
        end else if (rdEn) begin
            rdData <= rd_mux;
        end
    end
`else
    assign rdData = 8'hFF;
`endif

endmodule

// File: tb/tb_noise_reg_file.sv
// Randomized scoreboard bench for noise_reg_file (FS_DIV=4), with directed
// sequences for reset, trigger gating, power-down and read/write collisions.
module tb_noise_reg_file;

    localparam int F = 4;

    logic       clk = 1'b0;
    logic       resetN, apuEnable, wrEn, rdEn;
    logic [1:0] addr;
    logic [7:0] wrData;
    logic [7:0] rdData;
    logic       rdValid;
    logic [5:0] lenLoad;
    logic [3:0] startVol, clkShift;
    logic       envAdd, widthMode, lenEnable, trigger, dacEnable, lenClk, envClk;
    logic [2:0] envPeriod, divisor;

    noise_reg_file #(.FS_DIV(F)) dut (
        .clk(clk), .resetN(resetN), .apuEnable(apuEnable), .addr(addr),
        .wrEn(wrEn), .wrData(wrData), .rdEn(rdEn), .rdData(rdData),
        .rdValid(rdValid), .lenLoad(lenLoad), .startVol(startVol),
        .envAdd(envAdd), .envPeriod(envPeriod), .clkShift(clkShift),
        .widthMode(widthMode), .divisor(divisor), .lenEnable(lenEnable),
        .trigger(trigger), .dacEnable(dacEnable), .lenClk(lenClk),
        .envClk(envClk)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [7:0] data;
        int         due;
    } rd_exp_t;
    rd_exp_t rd_q[$];

    // Behavioural model of the architectural state.
    logic [5:0] m41;
    logic [7:0] m42, m43;
    logic       m44;
    logic       m_trig;
    int         m_en_cycles;

    function automatic logic [7:0] read_model(input logic [1:0] a, input logic ae);
`ifdef NOISE_REG_READBACK_EN
        if (a == 2'd0) return 8'hFF;
        if (a == 2'd1) return ae ? m42 : 8'h00;
        if (a == 2'd2) return ae ? m43 : 8'h00;
        return {1'b1, ae & m44, 6'h3F};
`else
        return 8'hFF;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    // Read monitor: pops expectations whenever the DUT qualifies read data.
    always @(negedge clk) begin
        if (rd_q.size() > 0 && rd_q[0].due < cycle) begin
            n_checks++;
            n_fail++;
            $display("FAIL rd_missing at cycle %0d: rdValid 0 expected 1", cycle);
            void'(rd_q.pop_front());
        end
        if (rdValid) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_spurious at cycle %0d: rdValid 1 expected 0", cycle);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                check("rd_latency", cycle, e.due);
                check("rd_data", int'(rdData), int'(e.data));
            end
        end
    end

    task automatic step(input logic rn, input logic ae, input logic we,
                        input logic re, input logic [1:0] a, input logic [7:0] d);
        int  t;
        bit  exp_len, exp_env;
        resetN = rn; apuEnable = ae; wrEn = we; rdEn = re; addr = a; wrData = d;
        if (rn && re) begin
            rd_exp_t e;
            e.data = read_model(a, ae);
            e.due  = cycle + 1;
            rd_q.push_back(e);
        end
        @(posedge clk);
        if (!rn || !ae) begin
            m41 = '0; m42 = '0; m43 = '0; m44 = 1'b0; m_trig = 1'b0; m_en_cycles = 0;
        end else begin
            m_trig = we && a == 2'd3 && d[7] && (m42[7:3] != 5'd0);
            if (we) begin
                case (a)
                    2'd0: m41 = d[5:0];
                    2'd1: m42 = d;
                    2'd2: m43 = d;
                    default: m44 = d[6];
                endcase
            end
            m_en_cycles++;
        end
        t = m_en_cycles;
        exp_len = (t > 0) && (t % F == 0) && (((t / F) % 8) % 2 == 0);
        exp_env = (t > 0) && (t % F == 0) && ((t / F) % 8 == 7);
        @(negedge clk);
        check("lenLoad", lenLoad, m41);
        check("nr42_fields", {startVol, envAdd, envPeriod}, m42);
        check("nr43_fields", {clkShift, widthMode, divisor}, m43);
        check("lenEnable", lenEnable, m44);
        check("dacEnable", dacEnable, m42[7:3] != 5'd0);
        check("trigger", trigger, m_trig);
        check("lenClk", lenClk, exp_len);
        check("envClk", envClk, exp_env);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        step(1'b1, 1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [1:0] a);
        step(1'b1, 1'b1, 1'b0, 1'b1, a, 8'h00);
    endtask

    initial begin
        resetN = 1'b0; apuEnable = 1'b1; wrEn = 1'b0; rdEn = 1'b0;
        addr = 2'd0; wrData = 8'h00;
        m41 = '0; m42 = '0; m43 = '0; m44 = 1'b0; m_trig = 1'b0; m_en_cycles = 0;
        @(negedge clk);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        check("rdValid_reset", rdValid, 0);
`ifdef NOISE_REG_READBACK_EN
        check("rdData_reset", rdData, 8'h00);
`else
        check("rdData_reset", rdData, 8'hFF);
`endif

        // Sequencer from reset, then reads of all addresses.
        idle(70);
        for (int i = 0; i < 4; i++) rd(2'(i));

        wr(2'd1, 8'hF3);
        wr(2'd2, 8'h5A);
        wr(2'd3, 8'hC0);
        idle(1);
        wr(2'd3, 8'h80);
        wr(2'd3, 8'h80);
        for (int i = 0; i < 4; i++) rd(2'(i));

        // Trigger gated by the DAC.
        wr(2'd1, 8'h00);
        wr(2'd3, 8'h80);
        wr(2'd1, 8'h08);
        wr(2'd3, 8'h80);
        wr(2'd0, 8'hFF);

        // Power-down clears fields and holds the sequencer.
        wr(2'd2, 8'hA5);
        step(1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 8'h00);
        step(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 8'hFF);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 2'(i % 4), 8'h00);
        rd(2'd2);

        // Same-cycle write and read of NR43.
        wr(2'd2, 8'h22);
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 8'h11);
        rd(2'd2);

        // Randomized traffic including occasional power-down and reset.
        for (int i = 0; i < 600; i++) begin
            logic rn, ae;
            rn = ($urandom_range(0, 99) != 0);
            ae = ($urandom_range(0, 39) != 0);
            step(rn, ae, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 8'($urandom));
        end
        idle(3);

        if (rd_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rd_pending: %0d reads outstanding expected 0", rd_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
